// File: rtl/game_state_nxn.sv
// N x N, K-in-a-row game controller: validates key moves, alternates players,
// detects win/draw and scans the player/result text onto two 7-segment digits.
module game_state_nxn #(
  parameter int unsigned N        = 3,
  parameter int unsigned K        = 3,
  parameter int unsigned KEY_W    = 6,
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_data,
  output logic [2*N*N-1:0]   board,
  output logic               turn_o,
  output logic [1:0]         result,
  output logic               busy,
  output logic               illegal,
  output logic [6:0]         seg_txt,
  output logic [7:0]         seg_com
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned CNT_W = $clog2(CELLS + 1);
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_P    = 7'b1110011;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_D    = 7'b1011110;
  localparam logic [6:0] SEG_R    = 7'b1010000;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [DIV_W-1:0]   div;
  logic               digit;

  logic [CELLS-1:0]   mine_c;
  logic [CELLS-1:0]   occ_c;
  logic               key_in_c;
  logic               occupied_c;
  logic               win_c;
  logic               full_c;
  logic [6:0]         txt_c;
  logic [7:0]         com_c;

  // Any horizontal, vertical, diagonal or anti-diagonal run of K marks in m.
  function automatic logic has_win(input logic [CELLS-1:0] m);
    logic run;
    has_win = 1'b0;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        if (c + int'(K) <= int'(N)) begin
          run = 1'b1;
          for (int k = 0; k < int'(K); k++) run = run & m[r*int'(N) + c + k];
          has_win = has_win | run;
        end
        if (r + int'(K) <= int'(N)) begin
          run = 1'b1;
          for (int k = 0; k < int'(K); k++) run = run & m[(r+k)*int'(N) + c];
          has_win = has_win | run;
        end
        if ((r + int'(K) <= int'(N)) && (c + int'(K) <= int'(N))) begin
          run = 1'b1;
          for (int k = 0; k < int'(K); k++) run = run & m[(r+k)*int'(N) + c + k];
          has_win = has_win | run;
        end
        if ((r + int'(K) <= int'(N)) && (c >= int'(K) - 1)) begin
          run = 1'b1;
          for (int k = 0; k < int'(K); k++) run = run & m[(r+k)*int'(N) + c - k];
          has_win = has_win | run;
        end
      end
    end
  endfunction

  // Per-cell views of the board, key legality and end-of-move evaluation.
  always_comb begin
    mine_c     = '0;
    occ_c      = '0;
    occupied_c = 1'b0;
    for (int i = 0; i < int'(CELLS); i++) begin
      mine_c[i] = turn_o ? board[2*i+1] : board[2*i];
      occ_c[i]  = board[2*i] | board[2*i+1];
      if (32'(key_data) == 32'(i)) occupied_c = occ_c[i];
    end
    key_in_c = 32'(key_data) < CELLS;
    win_c    = has_win(mine_c);
    full_c   = count == CNT_W'(CELLS);
  end

  // Text for the digit being driven this scan step.
  always_comb begin
    txt_c = SEG_DASH;
    com_c = digit ? 8'hBF : 8'h7F;
    case (state)
      IDLE:        txt_c = SEG_DASH;
      PLAY, CHECK: txt_c = digit ? (turn_o ? SEG_2 : SEG_1) : SEG_P;
      DONE: begin
        if (result == 2'b11) txt_c = digit ? SEG_R : SEG_D;
        else                 txt_c = digit ? ((result == 2'b10) ? SEG_2 : SEG_1) : SEG_P;
      end
      default:     txt_c = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      board   <= '0;
      turn_o  <= 1'b0;
      result  <= 2'b00;
      busy    <= 1'b0;
      illegal <= 1'b0;
      count   <= '0;
      div     <= '0;
      digit   <= 1'b0;
      seg_txt <= '0;
      seg_com <= 8'hFF;
    end else begin
      illegal <= 1'b0;
      seg_txt <= txt_c;
      seg_com <= com_c;
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div   <= '0;
        digit <= ~digit;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (new_game) begin
        board  <= '0;
        turn_o <= 1'b0;
        result <= 2'b00;
        busy   <= 1'b0;
        count  <= '0;
        state  <= PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (key_valid) begin
              if (!key_in_c || occupied_c) begin
                illegal <= 1'b1;
              end else begin
                for (int i = 0; i < int'(CELLS); i++) begin
                  if (32'(key_data) == 32'(i)) begin
                    if (turn_o) board[2*i+1] <= 1'b1;
                    else        board[2*i]   <= 1'b1;
                  end
                end
                count <= count + CNT_W'(1);
                busy  <= 1'b1;
                state <= CHECK;
              end
            end
          end
          // Only the player who just moved can have completed a line.
          CHECK: begin
            busy <= 1'b0;
            if (win_c) begin
              result <= turn_o ? 2'b10 : 2'b01;
              state  <= DONE;
            end else if (full_c) begin
              result <= 2'b11;
              state  <= DONE;
            end else begin
              result <= 2'b00;
              turn_o <= ~turn_o;
              state  <= PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_state_nxn.sv
// Directed bench for game_state_nxn: a 3x3/K=3 board plus a 4x4/K=3 board
// sharing the same key stream.
module tb_game_state_nxn;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic        key_valid;
  logic [5:0]  key_data;

  logic [17:0] board3;
  logic        turn3, busy3, illegal3;
  logic [1:0]  result3;
  logic [6:0]  seg_txt3;
  logic [7:0]  seg_com3;

  logic [31:0] board4;
  logic        turn4, busy4, illegal4;
  logic [1:0]  result4;
  logic [6:0]  seg_txt4;
  logic [7:0]  seg_com4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_state_nxn #(.N(3), .K(3), .KEY_W(6), .SCAN_DIV(4)) u3 (
    .clk(clk), .rst(rst), .new_game(new_game), .key_valid(key_valid), .key_data(key_data),
    .board(board3), .turn_o(turn3), .result(result3), .busy(busy3), .illegal(illegal3),
    .seg_txt(seg_txt3), .seg_com(seg_com3)
  );

  game_state_nxn #(.N(4), .K(3), .KEY_W(6), .SCAN_DIV(4)) u4 (
    .clk(clk), .rst(rst), .new_game(new_game), .key_valid(key_valid), .key_data(key_data),
    .board(board4), .turn_o(turn4), .result(result4), .busy(busy4), .illegal(illegal4),
    .seg_txt(seg_txt4), .seg_com(seg_com4)
  );

  // Stimulus helpers: called at a negedge, return at a negedge.
  task automatic start_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic press(input int k);
    key_data  = 6'(k);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic move(input int k);
    press(k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; new_game = 1'b0; key_valid = 1'b0; key_data = '0;
    repeat (3) @(negedge clk);
    total++; if (board3 !== 18'd0) begin bad++; $display("FAIL reset_board got=%0h exp=0", board3); end
    total++; if ({turn3, result3, busy3, illegal3} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {turn3, result3, busy3, illegal3}); end
    total++; if (seg_txt3 !== 7'd0 || seg_com3 !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h/%h exp=00/ff", seg_txt3, seg_com3); end
    rst = 1'b0;
    @(negedge clk);
    press(0);
    total++; if (illegal3 !== 1'b0 || board3 !== 18'd0) begin bad++; $display("FAIL idle_key got=%b/%0h exp=0/0", illegal3, board3); end
    @(negedge clk);
    total++; if (seg_txt3 !== 7'b1000000) begin bad++; $display("FAIL idle_text got=%b exp=1000000", seg_txt3); end
  endtask

  task automatic test_x_row();
    start_game();
    total++; if (turn3 !== 1'b0 || result3 !== 2'b00 || busy3 !== 1'b0) begin bad++; $display("FAIL ng_state got=%b%b%b exp=0000", turn3, result3, busy3); end
    move(0); move(3); move(1); move(4);
    total++; if (board3 !== 18'd645) begin bad++; $display("FAIL x_row_board4 got=%0d exp=645", board3); end
    press(2);
    total++; if (board3 !== 18'd661 || result3 !== 2'b00 || busy3 !== 1'b1) begin bad++; $display("FAIL x_row_t1 got=%0d/%b/%b exp=661/00/1", board3, result3, busy3); end
    @(negedge clk);
    total++; if (result3 !== 2'b01 || turn3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL x_row_win got=%b/%b/%b exp=01/0/0", result3, turn3, busy3); end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (!((seg_com3 === 8'h7F && seg_txt3 === 7'b1110011) || (seg_com3 === 8'hBF && seg_txt3 === 7'b0000110))) begin
        bad++; $display("FAIL x_win_text got=%h/%b exp=P1", seg_com3, seg_txt3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_o_column();
    start_game();
    move(0); move(1); move(3); move(4); move(8); move(7);
    total++; if (result3 !== 2'b10 || turn3 !== 1'b1) begin bad++; $display("FAIL o_col_win got=%b/%b exp=10/1", result3, turn3); end
    total++; if (board3 !== 18'd98889) begin bad++; $display("FAIL o_col_board got=%0d exp=98889", board3); end
    press(2);
    total++; if (board3 !== 18'd98889 || illegal3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL done_key got=%0d/%b/%b exp=98889/0/0", board3, illegal3, busy3); end
    @(negedge clk);
    total++;
    if (!((seg_com3 === 8'h7F && seg_txt3 === 7'b1110011) || (seg_com3 === 8'hBF && seg_txt3 === 7'b1011011))) begin
      bad++; $display("FAIL o_win_text got=%h/%b exp=P2", seg_com3, seg_txt3);
    end
  endtask

  task automatic test_illegal();
    start_game();
    move(4);
    total++; if (turn3 !== 1'b1 || board3 !== 18'd256) begin bad++; $display("FAIL ill_first got=%b/%0d exp=1/256", turn3, board3); end
    press(4);
    total++; if (illegal3 !== 1'b1 || turn3 !== 1'b1 || board3 !== 18'd256 || busy3 !== 1'b0) begin bad++; $display("FAIL ill_occupied got=%b/%b/%0d/%b exp=1/1/256/0", illegal3, turn3, board3, busy3); end
    @(negedge clk);
    total++; if (illegal3 !== 1'b0) begin bad++; $display("FAIL ill_pulse got=%b exp=0", illegal3); end
    press(9);
    total++; if (illegal3 !== 1'b1 || board3 !== 18'd256) begin bad++; $display("FAIL ill_range got=%b/%0d exp=1/256", illegal3, board3); end
    @(negedge clk);
  endtask

  task automatic test_draw();
    int changes;
    logic [7:0] prev;
    start_game();
    move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6);
    total++; if (result3 !== 2'b00 || turn3 !== 1'b0) begin bad++; $display("FAIL draw_pre got=%b/%b exp=00/0", result3, turn3); end
    move(8);
    total++; if (result3 !== 2'b11 || board3 !== 18'd92761) begin bad++; $display("FAIL draw_result got=%b/%0d exp=11/92761", result3, board3); end
    @(negedge clk);
    changes = 0;
    prev = seg_com3;
    for (int i = 0; i < 13; i++) begin
      total++;
      if (!((seg_com3 === 8'h7F && seg_txt3 === 7'b1011110) || (seg_com3 === 8'hBF && seg_txt3 === 7'b1010000))) begin
        bad++; $display("FAIL draw_text got=%h/%b exp=dr", seg_com3, seg_txt3);
      end
      if (seg_com3 !== prev) changes++;
      prev = seg_com3;
      @(negedge clk);
    end
    total++; if (changes != 3) begin bad++; $display("FAIL scan_rate got=%0d exp=3", changes); end
  endtask

  task automatic test_n4_diag();
    start_game();
    press(1);
    total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL n4_busy got=%b exp=1", busy4); end
    key_data = 6'd5; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    total++; if (board4 !== 32'd4 || illegal4 !== 1'b0 || turn4 !== 1'b1) begin bad++; $display("FAIL n4_busy_drop got=%0d/%b/%b exp=4/0/1", board4, illegal4, turn4); end
    move(0); move(6); move(2);
    total++; if (result4 !== 2'b00) begin bad++; $display("FAIL n4_pre got=%b exp=00", result4); end
    move(11);
    total++; if (result4 !== 2'b01 || board4 !== 32'd4198438) begin bad++; $display("FAIL n4_diag got=%b/%0d exp=01/4198438", result4, board4); end
  endtask

  task automatic test_restart();
    start_game();
    press(0);
    total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL mid_check_busy got=%b exp=1", busy3); end
    rst = 1'b1;
    #1;
    total++; if (board3 !== 18'd0 || result3 !== 2'b00 || seg_com3 !== 8'hFF || busy3 !== 1'b0) begin bad++; $display("FAIL async_rst got=%0d/%b/%h/%b exp=0/00/ff/0", board3, result3, seg_com3, busy3); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_game();
    move(0); move(3); move(1); move(4); move(2);
    total++; if (result3 !== 2'b01) begin bad++; $display("FAIL rewin got=%b exp=01", result3); end
    start_game();
    total++; if (board3 !== 18'd0 || result3 !== 2'b00 || turn3 !== 1'b0) begin bad++; $display("FAIL restart got=%0d/%b/%b exp=0/00/0", board3, result3, turn3); end
    move(4);
    total++; if (board3 !== 18'd256 || turn3 !== 1'b1) begin bad++; $display("FAIL restart_move got=%0d/%b exp=256/1", board3, turn3); end
  endtask

  initial begin
    test_reset();
    test_x_row();
    test_o_column();
    test_illegal();
    test_draw();
    test_n4_diag();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
